// File: rtl/audio_codec_cfg.sv
// WM8731 configuration sequencer: writes the codec register table over I2C
// after reset or on request, and serves runtime headphone-volume writes.
module audio_codec_cfg #(
    parameter int         CLK_FREQ  = 18432000,
    parameter int         I2C_FREQ  = 100000,
    parameter logic [6:0] DEV_ADDR  = 7'h1A,
    parameter int         RETRY_MAX = 3
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iSTART,
    input  logic       iVOL_REQ,
    input  logic [6:0] iVOL,
    output logic       oVOL_ACK,
    output logic       oI2C_SCLK,
    inout  wire        ioI2C_SDAT,
    output logic       oBUSY,
    output logic       oCFG_DONE,
    output logic       oCFG_ERR
);

    localparam int DIV_RAW = CLK_FREQ / (4 * I2C_FREQ);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [3:0]    TBL_LAST = 4'd9;
    localparam logic [7:0]    RMAX     = 8'(RETRY_MAX);
    // Bus-free ticks spent in GAP; the NEXT tick completes three bit periods
    localparam logic [3:0]    GAP_LAST = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_GAP, S_NEXT
    } state_t;

    typedef struct packed {
        logic [6:0] addr;
        logic [8:0] data;
    } wr_t;

    // Register table in write order; R15 resets the codec, R9 activates it
    function automatic wr_t tbl_entry(input logic [3:0] i);
        case (i)
            4'd0:    tbl_entry = '{addr: 7'd15, data: 9'h000};
            4'd1:    tbl_entry = '{addr: 7'd6,  data: 9'h000};
            4'd2:    tbl_entry = '{addr: 7'd0,  data: 9'h017};
            4'd3:    tbl_entry = '{addr: 7'd1,  data: 9'h017};
            4'd4:    tbl_entry = '{addr: 7'd2,  data: 9'h179};
            4'd5:    tbl_entry = '{addr: 7'd4,  data: 9'h012};
            4'd6:    tbl_entry = '{addr: 7'd5,  data: 9'h000};
            4'd7:    tbl_entry = '{addr: 7'd7,  data: 9'h002};
            4'd8:    tbl_entry = '{addr: 7'd8,  data: 9'h002};
            4'd9:    tbl_entry = '{addr: 7'd9,  data: 9'h001};
            default: tbl_entry = '{addr: 7'd0,  data: 9'h000};
        endcase
    endfunction

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]    ph_q, ph_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic [3:0]    idx_q, idx_d;
    logic [7:0]    retry_q, retry_d;
    logic          job_vol_q, job_vol_d;
    logic [6:0]    vol_q, vol_d;
    logic          nack_q, nack_d;
    logic          sda_q, sda_d;
    logic          pend_q, pend_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          ack_q, ack_d;
    logic          blk_q, blk_d;
    logic          start_prev_q;

    logic       tick;
    logic       start_edge;
    logic       sda_in;
    wr_t        cur;
    logic [7:0] cur_byte;
    logic       cur_bit;
    logic       scl;

    assign tick       = (div_q == DIV_LAST);
    assign start_edge = iSTART & ~start_prev_q;
    assign sda_in     = ioI2C_SDAT;

    // Divider: one-cycle tick every DIV clocks
    always_comb div_d = tick ? '0 : div_q + DW'(1);

    // Current write word and the bit presently on the wire
    always_comb begin
        cur = job_vol_q ? '{addr: 7'd2, data: {2'b10, vol_q}} : tbl_entry(idx_q);
        case (byte_q)
            2'd0:    cur_byte = {DEV_ADDR, 1'b0};
            2'd1:    cur_byte = {cur.addr, cur.data[8]};
            default: cur_byte = cur.data[7:0];
        endcase
        cur_bit = cur_byte[3'd7 - bit_q];
    end

    // SCL is low for the first half of every data, ACK and STOP slot
    always_comb begin
        scl = 1'b1;
        if (state_q == S_BIT || state_q == S_ACK || state_q == S_STOP)
            scl = ph_q[1];
    end

    // Next-state logic: bus sequencing, retries and job arbitration
    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        idx_d     = idx_q;
        retry_d   = retry_q;
        job_vol_d = job_vol_q;
        vol_d     = vol_q;
        nack_d    = nack_q;
        sda_d     = sda_q;
        pend_d    = pend_q;
        done_d    = done_q;
        err_d     = err_q;
        ack_d     = 1'b0;
        blk_d     = blk_q;

        if (state_q == S_IDLE && start_edge) pend_d = 1'b1;
        if (!iVOL_REQ) blk_d = 1'b0;

        if (tick) begin
            if (state_q != S_IDLE) ph_d = ph_q + 2'd1;
            case (state_q)
                S_IDLE: begin
                    // Volume wins a tie; a latched table run follows it
                    if (iVOL_REQ && !blk_q) begin
                        job_vol_d = 1'b1;
                        vol_d     = iVOL;
                        retry_d   = '0;
                        nack_d    = 1'b0;
                        ph_d      = '0;
                        state_d   = S_START;
                    end else if (pend_q) begin
                        job_vol_d = 1'b0;
                        idx_d     = '0;
                        retry_d   = '0;
                        nack_d    = 1'b0;
                        pend_d    = 1'b0;
                        done_d    = 1'b0;
                        err_d     = 1'b0;
                        ph_d      = '0;
                        state_d   = S_START;
                    end
                end
                S_START: begin
                    if (ph_q == 2'd1) sda_d = 1'b0;
                    if (ph_q == 2'd3) begin
                        bit_d   = '0;
                        byte_d  = '0;
                        state_d = S_BIT;
                    end
                end
                S_BIT: begin
                    if (ph_q == 2'd0) sda_d = cur_bit;
                    if (ph_q == 2'd3) begin
                        if (bit_q == 3'd7) state_d = S_ACK;
                        else               bit_d   = bit_q + 3'd1;
                    end
                end
                S_ACK: begin
                    if (ph_q == 2'd0) sda_d = 1'b1;
                    if (ph_q == 2'd3) begin
                        // A NACK ends the transaction early; NEXT decides the retry
                        if (sda_in != 1'b0) begin
                            nack_d  = 1'b1;
                            state_d = S_STOP;
                        end else if (byte_q == 2'd2) begin
                            state_d = S_STOP;
                        end else begin
                            byte_d  = byte_q + 2'd1;
                            bit_d   = '0;
                            state_d = S_BIT;
                        end
                    end
                end
                S_STOP: begin
                    if (ph_q == 2'd0) sda_d = 1'b0;
                    if (ph_q == 2'd2) sda_d = 1'b1;
                    if (ph_q == 2'd3) begin
                        bit_d   = '0;
                        state_d = S_GAP;
                    end
                end
                S_GAP: begin
                    if ({bit_q[1:0], ph_q} == GAP_LAST) begin
                        ph_d    = '0;
                        bit_d   = '0;
                        state_d = S_NEXT;
                    end else if (ph_q == 2'd3) begin
                        bit_d = bit_q + 3'd1;
                    end
                end
                S_NEXT: begin
                    ph_d = '0;
                    if (nack_q && retry_q < RMAX) begin
                        retry_d = retry_q + 8'd1;
                        nack_d  = 1'b0;
                        state_d = S_START;
                    end else if (job_vol_q) begin
                        // Completed or given up: either way the requester is released
                        ack_d   = 1'b1;
                        blk_d   = 1'b1;
                        nack_d  = 1'b0;
                        state_d = S_IDLE;
                    end else if (nack_q) begin
                        err_d   = 1'b1;
                        nack_d  = 1'b0;
                        state_d = S_IDLE;
                    end else if (idx_q == TBL_LAST) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        retry_d = '0;
                        state_d = S_START;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State registers; reset drops the bus immediately with no STOP
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q      <= S_IDLE;
            div_q        <= '0;
            ph_q         <= '0;
            bit_q        <= '0;
            byte_q       <= '0;
            idx_q        <= '0;
            retry_q      <= '0;
            job_vol_q    <= 1'b0;
            vol_q        <= '0;
            nack_q       <= 1'b0;
            sda_q        <= 1'b1;
            pend_q       <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            ack_q        <= 1'b0;
            blk_q        <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            ph_q         <= ph_d;
            bit_q        <= bit_d;
            byte_q       <= byte_d;
            idx_q        <= idx_d;
            retry_q      <= retry_d;
            job_vol_q    <= job_vol_d;
            vol_q        <= vol_d;
            nack_q       <= nack_d;
            sda_q        <= sda_d;
            pend_q       <= pend_d;
            done_q       <= done_d;
            err_q        <= err_d;
            ack_q        <= ack_d;
            blk_q        <= blk_d;
            start_prev_q <= iSTART;
        end
    end

    assign ioI2C_SDAT = sda_q ? 1'bz : 1'b0;
    assign oI2C_SCLK  = scl;
    assign oBUSY      = (state_q != S_IDLE);
    assign oCFG_DONE  = done_q;
    assign oCFG_ERR   = err_q;
    assign oVOL_ACK   = ack_q;

endmodule

// File: tb/tb_audio_codec_cfg.sv
// Bench for audio_codec_cfg: I2C slave model feeding a write scoreboard.
module tb_audio_codec_cfg;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       vol_req = 1'b0;
    logic [6:0] vol = 7'h00;
    wire        vol_ack, scl, busy, done, err;
    wire        sda;
    logic       slave_pull = 1'b0;

    pullup (sda);
    assign sda = slave_pull ? 1'b0 : 1'bz;

    audio_codec_cfg #(
        .CLK_FREQ (400000),
        .I2C_FREQ (100000),
        .DEV_ADDR (7'h1A),
        .RETRY_MAX(3)
    ) dut (
        .iCLK      (clk),
        .iRST_N    (rst_n),
        .iSTART    (start),
        .iVOL_REQ  (vol_req),
        .iVOL      (vol),
        .oVOL_ACK  (vol_ack),
        .oI2C_SCLK (scl),
        .ioI2C_SDAT(sda),
        .oBUSY     (busy),
        .oCFG_DONE (done),
        .oCFG_ERR  (err)
    );

    always #5 clk = ~clk;

    // Expected bus writes {addr byte, byte1, byte2}, hand-computed
    logic [23:0] tbl [10] = '{24'h341E00, 24'h340C00, 24'h340017, 24'h340217,
                              24'h340579, 24'h340812, 24'h340A00, 24'h340E02,
                              24'h341002, 24'h341201};

    int compared = 0;
    int mism = 0;
    logic [23:0] exp_q[$];
    logic [23:0] obs_q[$];

    // Slave model state
    int         mode = 0;      // 0 ack all, 1 nack first R4, 2 nack all
    bit         r4_nacked = 0;
    int         nwrites = 0;
    int         nbits = 0;
    int         nbytes = 0;
    bit         in_tx = 0;
    bit         ack_slot = 0;
    bit         ack_pend = 0;
    logic       p_scl = 1'b1;
    logic       p_sda = 1'b1;
    logic [7:0] sh = 8'h00;
    logic [7:0] rx [3];
    int         ack_cnt = 0;

    // I2C slave: decodes START/bits/STOP and answers each ACK slot
    always @(negedge clk) begin
        if (!rst_n) begin
            in_tx = 0; ack_slot = 0; ack_pend = 0; slave_pull = 1'b0;
        end else if (p_scl && scl && p_sda && !sda) begin
            in_tx = 1; nbits = 0; nbytes = 0; ack_slot = 0; ack_pend = 0;
            rx[0] = 8'h00; rx[1] = 8'h00; rx[2] = 8'h00;
        end else if (p_scl && scl && !p_sda && sda) begin
            if (in_tx) begin
                obs_q.push_back({rx[0], rx[1], rx[2]});
                nwrites++;
            end
            in_tx = 0; slave_pull = 1'b0;
        end else if (in_tx && !p_scl && scl && !ack_slot) begin
            sh = {sh[6:0], sda};
            nbits++;
            if (nbits == 8) begin
                if (nbytes < 3) rx[nbytes] = sh;
                nbytes++;
                nbits = 0;
                ack_pend = 1;
            end
        end else if (in_tx && p_scl && !scl) begin
            if (ack_pend) begin
                ack_pend = 0; ack_slot = 1;
                if (nbytes == 3 && mode == 2) slave_pull = 1'b0;
                else if (nbytes == 3 && mode == 1 && rx[1] == 8'h08 && !r4_nacked) begin
                    slave_pull = 1'b0; r4_nacked = 1;
                end else slave_pull = 1'b1;
            end else if (ack_slot) begin
                ack_slot = 0; slave_pull = 1'b0;
            end
        end
        p_scl = scl;
        p_sda = sda;
    end

    // Monitor: every observed write is checked against the expected queue
    always @(posedge clk) begin
        logic [23:0] o, e;
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            compared++;
            if (exp_q.size() == 0) begin
                mism++;
                $display("FAIL write: got %06h, required none", o);
            end else begin
                e = exp_q.pop_front();
                if (o !== e) begin
                    mism++;
                    $display("FAIL write: got %06h, required %06h", o, e);
                end
            end
        end
    end

    always @(negedge clk) if (vol_ack === 1'b1) ack_cnt++;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mism++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic push_tbl();
        foreach (tbl[i]) exp_q.push_back(tbl[i]);
    endtask

    task automatic wait_busy(input logic lvl, input int budget, input string nm);
        int n = 0;
        while (busy !== lvl && n < budget) begin step(); n++; end
        chk(nm, {31'd0, busy}, {31'd0, lvl});
    endtask

    task automatic wait_ack(input int budget, input string nm);
        int n = 0;
        while (vol_ack !== 1'b1 && n < budget) begin step(); n++; end
        chk(nm, {31'd0, vol_ack}, 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        wait_busy(1'b1, 20, "table start");
        start = 1'b0;
    endtask

    initial begin
        int n;
        int a0;
        int w0;

        // Reset state
        repeat (3) step();
        chk("rst scl", {31'd0, scl}, 32'd1);
        chk("rst sda", {31'd0, sda}, 32'd1);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst err", {31'd0, err}, 32'd0);
        chk("rst vol_ack", {31'd0, vol_ack}, 32'd0);

        // Automatic table after reset release, always-ACK slave
        push_tbl();
        rst_n = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < 2000) begin step(); n++; end
        chk("table time ok", {31'd0, (n >= 1280 && n <= 1282)}, 32'd1);
        chk("table done", {31'd0, done}, 32'd1);
        chk("table busy", {31'd0, busy}, 32'd0);
        chk("table err", {31'd0, err}, 32'd0);
        repeat (4) step();
        chk("table remaining", exp_q.size(), 32'd0);

        // Slave NACKs the first R4 attempt only
        mode = 1; r4_nacked = 0;
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(tbl[i]);
            if (i == 5) exp_q.push_back(tbl[i]);
        end
        pulse_start();
        chk("rerun done drop", {31'd0, done}, 32'd0);
        wait_busy(1'b0, 3000, "r4 retry end");
        chk("r4 done", {31'd0, done}, 32'd1);
        chk("r4 err", {31'd0, err}, 32'd0);
        repeat (4) step();
        chk("r4 remaining", exp_q.size(), 32'd0);

        // Slave NACKs everything: 4 attempts of R15, then error
        mode = 2;
        w0 = nwrites;
        repeat (4) exp_q.push_back(tbl[0]);
        pulse_start();
        wait_busy(1'b0, 2000, "nack end");
        chk("nack err", {31'd0, err}, 32'd1);
        chk("nack done", {31'd0, done}, 32'd0);
        repeat (600) step();
        chk("nack idle", {31'd0, busy}, 32'd0);
        chk("nack writes", nwrites - w0, 32'd4);
        chk("nack remaining", exp_q.size(), 32'd0);

        // Volume request mid-table waits until after R9
        mode = 0;
        push_tbl();
        exp_q.push_back(24'h340550);
        a0 = ack_cnt;
        pulse_start();
        chk("rerun err clear", {31'd0, err}, 32'd0);
        repeat (300) step();
        vol = 7'h50; vol_req = 1'b1;
        wait_ack(3000, "vol ack");
        chk("vol after done", {31'd0, done}, 32'd1);
        vol = 7'h11;
        repeat (3) step();
        vol_req = 1'b0;
        repeat (200) step();
        chk("vol ack pulses", ack_cnt - a0, 32'd1);
        chk("vol remaining", exp_q.size(), 32'd0);

        // Volume and iSTART edge in the same idle cycle: volume first
        exp_q.push_back(24'h34052A);
        push_tbl();
        vol = 7'h2A; vol_req = 1'b1; start = 1'b1;
        wait_ack(400, "tie vol ack");
        chk("tie done before rerun", {31'd0, done}, 32'd1);
        vol_req = 1'b0; start = 1'b0;
        wait_busy(1'b1, 20, "tie table start");
        chk("tie done drop", {31'd0, done}, 32'd0);
        wait_busy(1'b0, 2000, "tie table end");
        chk("tie done", {31'd0, done}, 32'd1);
        repeat (4) step();
        chk("tie remaining", exp_q.size(), 32'd0);

        // Reset during byte 1 of R0, then table restarts from R15
        exp_q.push_back(tbl[0]);
        exp_q.push_back(tbl[1]);
        w0 = nwrites;
        pulse_start();
        n = 0;
        while (!(nwrites == w0 + 2 && in_tx && nbytes == 1 && nbits == 3) && n < 1000) begin
            step(); n++;
        end
        chk("r0 byte1 reached", {31'd0, (n < 1000)}, 32'd1);
        step(); step();
        chk("pre-reset sda low", {31'd0, sda}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid rst scl", {31'd0, scl}, 32'd1);
        chk("mid rst sda", {31'd0, sda}, 32'd1);
        chk("mid rst busy", {31'd0, busy}, 32'd0);
        repeat (3) step();
        push_tbl();
        rst_n = 1'b1;
        wait_busy(1'b1, 20, "restart busy");
        wait_busy(1'b0, 2000, "restart end");
        chk("restart done", {31'd0, done}, 32'd1);
        repeat (4) step();
        chk("restart remaining", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
